// File: rtl/slice_array_sched_pkg.sv
// Shared constants and types for the slice array scheduler.
package slice_array_pkg;

    localparam int SLICE_W = 12;
    localparam int NUNIT   = 3;
    localparam int DP_W    = 36;
    localparam int UNIT_W  = 2;
    // Wide enough for the largest supported requester count (8).
    localparam int ID_W    = 3;

    localparam logic [UNIT_W-1:0] UNIT_ILLEGAL = 2'd3;

    // Which requester owns a unit's in-flight operation.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } unit_owner_t;

endpackage

// File: rtl/slice_array_sched_rr_arb.sv
// Round-robin arbiter: one-hot grant, search starts at ptr, ptr moves past the winner.
module rr_arb #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic [PTR_W-1:0] idx;
    logic             hit;

    // Scan requesters starting at ptr; first active one wins.
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        hit     = 1'b0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NREQ);
            if (!hit && req[idx]) begin
                hit        = 1'b1;
                grant[idx] = 1'b1;
                ptr_nxt    = PTR_W'((int'(idx) + 1) % NREQ);
            end
        end
    end

    // Pointer only moves when something was granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else        ptr <= ptr_nxt;
    end

endmodule

// File: rtl/slice_array_sched.sv
// Shares the three 12-bit INV/OAI222 array units among NREQ requesters with
// per-unit round-robin arbitration and a fixed two-cycle response latency.
module slice_array_sched
    import slice_array_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [2*NREQ-1:0]       req_unit,
    input  logic [SLICE_W*NREQ-1:0] req_a,
    input  logic [SLICE_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic [DP_W-1:0]         dp_a,
    output logic [DP_W-1:0]         dp_b,
    input  logic [DP_W-1:0]         dp_c,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [SLICE_W*NREQ-1:0] rsp_data,
    output logic [NREQ-1:0]         rsp_err,
    output logic [15:0]             issue_cnt
);

    logic [NUNIT-1:0][NREQ-1:0]    unit_req;
    logic [NUNIT-1:0][NREQ-1:0]    unit_gnt;
    logic [NREQ-1:0]               illegal;
    logic [NREQ-1:0]               granted;
    unit_owner_t [NUNIT-1:0]       win;
    unit_owner_t [NUNIT-1:0]       owner;
    logic [NUNIT-1:0][SLICE_W-1:0] sel_a;
    logic [NUNIT-1:0][SLICE_W-1:0] sel_b;
    logic [NREQ-1:0]               ill_s1;
    logic [1:0]                    n_grants;
    logic [16:0]                   cnt_sum;

    // Split requests into per-unit candidate vectors; unit 3 bypasses arbitration.
    always_comb begin
        unit_req = '0;
        illegal  = '0;
        for (int i = 0; i < NREQ; i++) begin
            illegal[i] = req_valid[i] && (req_unit[UNIT_W*i +: UNIT_W] == UNIT_ILLEGAL);
            for (int u = 0; u < NUNIT; u++)
                if (req_valid[i] && (req_unit[UNIT_W*i +: UNIT_W] == UNIT_W'(u)))
                    unit_req[u][i] = 1'b1;
        end
    end

    for (genvar u = 0; u < NUNIT; u++) begin : g_unit
        rr_arb #(.NREQ(NREQ)) u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (unit_req[u]),
            .grant (unit_gnt[u])
        );
    end

    // Turn one-hot grants into owner ids and muxed operands; count legal issues.
    always_comb begin
        win      = '0;
        sel_a    = '0;
        sel_b    = '0;
        n_grants = '0;
        granted  = illegal;
        for (int u = 0; u < NUNIT; u++) begin
            granted = granted | unit_gnt[u];
            for (int i = 0; i < NREQ; i++)
                if (unit_gnt[u][i]) begin
                    win[u].valid = 1'b1;
                    win[u].id    = ID_W'(i);
                    sel_a[u]     = req_a[SLICE_W*i +: SLICE_W];
                    sel_b[u]     = req_b[SLICE_W*i +: SLICE_W];
                end
            n_grants = n_grants + {1'b0, win[u].valid};
        end
        req_ready = granted & {NREQ{rst_n}};
    end

    // Stage 1: drive winners onto the array; idle units keep their last operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_a   <= '0;
            dp_b   <= '0;
            owner  <= '0;
            ill_s1 <= '0;
        end else begin
            owner  <= win;
            ill_s1 <= illegal;
            for (int u = 0; u < NUNIT; u++)
                if (win[u].valid) begin
                    dp_a[SLICE_W*u +: SLICE_W] <= sel_a[u];
                    dp_b[SLICE_W*u +: SLICE_W] <= sel_b[u];
                end
        end
    end

    // Stage 2: route each unit's result back to its owner; illegal ops return zero with err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_err   <= '0;
            rsp_data  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                rsp_valid[i] <= ill_s1[i];
                rsp_err[i]   <= ill_s1[i];
                if (ill_s1[i]) rsp_data[SLICE_W*i +: SLICE_W] <= '0;
                for (int u = 0; u < NUNIT; u++)
                    if (owner[u].valid && (owner[u].id == ID_W'(i))) begin
                        rsp_valid[i]                    <= 1'b1;
                        rsp_data[SLICE_W*i +: SLICE_W] <= dp_c[SLICE_W*u +: SLICE_W];
                    end
            end
        end
    end

    assign cnt_sum = {1'b0, issue_cnt} + 17'(n_grants);

    // Saturating count of legal issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          issue_cnt <= '0;
        else if (cnt_sum[16]) issue_cnt <= 16'hFFFF;
        else                 issue_cnt <= cnt_sum[15:0];
    end

endmodule

// File: tb/tb_slice_array_sched.sv
// Randomized bench with a queue-based reference model plus directed scenarios.
module tb_slice_array_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [7:0]  req_unit;
    logic [47:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic [35:0] dp_a, dp_b, dp_c;
    logic [3:0]  rsp_valid;
    logic [47:0] rsp_data;
    logic [3:0]  rsp_err;
    logic [15:0] issue_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    slice_array_sched #(.NREQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_unit(req_unit),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .dp_a(dp_a), .dp_b(dp_b),
        .dp_c(dp_c), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .issue_cnt(issue_cnt)
    );

    // The array itself, one 12-bit unit at a time.
    function automatic logic [11:0] grp12(input logic [11:0] a, input logic [11:0] b);
        logic [11:0] r;
        logic [3:0]  x, y;
        r = '0;
        for (int g = 0; g < 3; g++) begin
            x = a[4*g +: 4];
            y = b[4*g +: 4];
            r[4*g]   = ~x[0];
            r[4*g+1] = ~y[0];
            r[4*g+2] = ~y[1];
            r[4*g+3] = ~((x[1] | x[2]) & (y[1] | y[2]) & (x[3] | y[3]));
        end
        return r;
    endfunction

    assign dp_c = {grp12(dp_a[35:24], dp_b[35:24]), grp12(dp_a[23:12], dp_b[23:12]),
                   grp12(dp_a[11:0], dp_b[11:0])};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        int          id;
        bit          err;
        logic [11:0] data;
    } exp_t;

    exp_t        q[$];
    exp_t        keep[$];
    int          cyc = 0;
    int          m_ptr[3];
    logic [35:0] m_dp_a, m_dp_b;
    logic [11:0] m_data[4];
    int          m_cnt;
    logic [3:0]  prev_v, prev_r;
    logic [7:0]  prev_u;
    logic [47:0] prev_a, prev_b;
    bit          prev_ok = 0;
    logic [3:0]  ev, ee, er;
    int          gcnt, idx;
    bit          found;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int u = 0; u < 3; u++) m_ptr[u] = 0;
            for (int i = 0; i < 4; i++) m_data[i] = '0;
            m_dp_a = '0; m_dp_b = '0; m_cnt = 0;
            q.delete();
            prev_ok = 0;
            chk("rst_ready", 64'(req_ready), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_rsp_err", 64'(rsp_err), 64'd0);
            chk("rst_rsp_data", 64'(rsp_data), 64'd0);
            chk("rst_dp_a", 64'(dp_a), 64'd0);
            chk("rst_dp_b", 64'(dp_b), 64'd0);
            chk("rst_issue_cnt", 64'(issue_cnt), 64'd0);
        end else begin
            // Requests stalled last cycle must be presented unchanged.
            if (prev_ok)
                for (int i = 0; i < 4; i++)
                    if (prev_v[i] && !prev_r[i])
                        chk("req_hold", {req_valid[i], req_unit[2*i +: 2], req_a[12*i +: 12], req_b[12*i +: 12]},
                            {1'b1, prev_u[2*i +: 2], prev_a[12*i +: 12], prev_b[12*i +: 12]});
            // Responses due this cycle.
            ev = '0; ee = '0;
            keep.delete();
            foreach (q[k]) begin
                if (q[k].due == cyc) begin
                    ev[q[k].id]     = 1'b1;
                    ee[q[k].id]     = q[k].err;
                    m_data[q[k].id] = q[k].data;
                end else keep.push_back(q[k]);
            end
            q = keep;
            chk("rsp_valid", 64'(rsp_valid), 64'(ev));
            chk("rsp_err", 64'(rsp_err), 64'(ee));
            chk("rsp_data", 64'(rsp_data), 64'({m_data[3], m_data[2], m_data[1], m_data[0]}));
            chk("dp_a", 64'(dp_a), 64'(m_dp_a));
            chk("dp_b", 64'(dp_b), 64'(m_dp_b));
            chk("issue_cnt", 64'(issue_cnt), 64'(m_cnt));
            // Acceptances this cycle.
            er = '0; gcnt = 0;
            for (int u = 0; u < 3; u++) begin
                found = 0;
                for (int k = 0; k < 4; k++) begin
                    idx = (m_ptr[u] + k) % 4;
                    if (!found && req_valid[idx] && int'(req_unit[2*idx +: 2]) == u) begin
                        found = 1;
                        er[idx] = 1'b1;
                        gcnt++;
                        q.push_back('{cyc + 2, idx, 1'b0, grp12(req_a[12*idx +: 12], req_b[12*idx +: 12])});
                        m_dp_a[12*u +: 12] = req_a[12*idx +: 12];
                        m_dp_b[12*u +: 12] = req_b[12*idx +: 12];
                    end
                end
                if (found) m_ptr[u] = (q[$].id + 1) % 4;
            end
            for (int i = 0; i < 4; i++)
                if (req_valid[i] && req_unit[2*i +: 2] == 2'd3) begin
                    er[i] = 1'b1;
                    q.push_back('{cyc + 2, i, 1'b1, 12'h000});
                end
            chk("req_ready", 64'(req_ready), 64'(er));
            m_cnt = (m_cnt + gcnt > 65535) ? 65535 : m_cnt + gcnt;
            prev_v = req_valid; prev_r = req_ready; prev_u = req_unit;
            prev_a = req_a; prev_b = req_b; prev_ok = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_req(input int i, input bit v, input logic [1:0] u,
                           input logic [11:0] a, input logic [11:0] b);
        req_valid[i]       = v;
        req_unit[2*i +: 2] = u;
        req_a[12*i +: 12]  = a;
        req_b[12*i +: 12]  = b;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  acc;
    logic [35:0] save_a, save_b;
    int          rcnt[4];
    bit          drained;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_unit = '0; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset.
        repeat (20) next_cycle();
        chk("idle_dp_a", 64'(dp_a), 64'd0);
        chk("idle_cnt", 64'(issue_cnt), 64'd0);

        // Single op on unit 0, all-zero then all-one operands.
        set_req(0, 1, 2'd0, 12'h000, 12'h000);
        @(negedge clk) chk("t2_ready0", 64'(req_ready[0]), 64'd1);
        next_cycle(); set_req(0, 0, 2'd0, 12'h000, 12'h000);
        @(posedge clk);
        @(negedge clk);
        chk("t2_rsp0_valid", 64'(rsp_valid), 64'h1);
        chk("t2_rsp0_data", 64'(rsp_data[11:0]), 64'hFFF);
        next_cycle();
        set_req(0, 1, 2'd0, 12'hFFF, 12'hFFF);
        next_cycle(); set_req(0, 0, 2'd0, 12'h000, 12'h000);
        @(posedge clk);
        @(negedge clk);
        chk("t2_rsp1_valid", 64'(rsp_valid), 64'h1);
        chk("t2_rsp1_data", 64'(rsp_data[11:0]), 64'h000);
        chk("t2_cnt", 64'(issue_cnt), 64'd2);
        repeat (3) next_cycle();

        // Four requesters contend for unit 1; each leaves after its second grant.
        for (int i = 0; i < 4; i++) begin
            set_req(i, 1, 2'd1, 12'h111 * 12'(i + 1), 12'h000);
            rcnt[i] = 0;
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t3_order", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            for (int i = 0; i < 4; i++) rcnt[i] += int'(rsp_valid[i]);
            next_cycle();
            if (k >= 4) set_req(k % 4, 0, 2'd0, 12'h000, 12'h000);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) rcnt[i] += int'(rsp_valid[i]);
        end
        for (int i = 0; i < 4; i++) chk("t3_rsp_count", 64'(rcnt[i]), 64'd2);
        chk("t3_dp_u0", 64'(dp_a[11:0]), 64'hFFF);
        chk("t3_dp_u2", 64'(dp_a[35:24]), 64'h000);
        chk("t3_rsp3_data", 64'(rsp_data[47:36]), 64'hFFF);
        next_cycle();

        // One requester per unit in the same cycle.
        set_req(0, 1, 2'd0, 12'h123, 12'h456);
        set_req(1, 1, 2'd1, 12'h789, 12'hABC);
        set_req(2, 1, 2'd2, 12'hDEF, 12'h012);
        @(negedge clk) chk("t4_ready", 64'(req_ready), 64'h7);
        next_cycle();
        for (int i = 0; i < 3; i++) set_req(i, 0, 2'd0, 12'h000, 12'h000);
        @(posedge clk);
        @(negedge clk);
        chk("t4_rsp_valid", 64'(rsp_valid), 64'h7);
        chk("t4_cnt", 64'(issue_cnt), 64'd13);
        next_cycle();

        // Illegal unit index.
        save_a = dp_a; save_b = dp_b;
        set_req(3, 1, 2'd3, 12'h5A5, 12'hA5A);
        @(negedge clk) chk("t5_ready", 64'(req_ready), 64'h8);
        next_cycle(); set_req(3, 0, 2'd0, 12'h000, 12'h000);
        @(posedge clk);
        @(negedge clk);
        chk("t5_rsp_valid", 64'(rsp_valid), 64'h8);
        chk("t5_rsp_err", 64'(rsp_err), 64'h8);
        chk("t5_rsp_data", 64'(rsp_data[47:36]), 64'h000);
        chk("t5_cnt", 64'(issue_cnt), 64'd13);
        chk("t5_dp_a", 64'(dp_a), 64'(save_a));
        chk("t5_dp_b", 64'(dp_b), 64'(save_b));
        next_cycle();

        // Reset while two ops are in flight.
        set_req(0, 1, 2'd0, 12'h0F0, 12'h00F);
        set_req(1, 1, 2'd1, 12'h0F0, 12'h00F);
        next_cycle();
        set_req(0, 0, 2'd0, 12'h000, 12'h000);
        set_req(1, 0, 2'd0, 12'h000, 12'h000);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t6_no_rsp", 64'(rsp_valid), 64'd0);
        end
        chk("t6_cnt", 64'(issue_cnt), 64'd0);
        next_cycle();
        for (int i = 0; i < 4; i++) set_req(i, 1, 2'd1, 12'h321, 12'h654);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) chk("t6_ptr_restart", 64'(req_ready), 64'h1);
            next_cycle();
            set_req(k, 0, 2'd0, 12'h000, 12'h000);
        end
        repeat (3) next_cycle();

        // Random traffic; stalled requests are held until accepted.
        acc = '0;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 4; i++)
                if (!req_valid[i] || acc[i])
                    set_req(i, $urandom_range(0, 99) < 60,
                            ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                            12'($urandom), 12'($urandom));
            @(negedge clk) acc = req_valid & req_ready;
            next_cycle();
        end
        drained = 0;
        for (int n = 0; n < 50 && !drained; n++) begin
            for (int i = 0; i < 4; i++)
                if (acc[i]) set_req(i, 0, 2'd0, 12'h000, 12'h000);
            drained = (req_valid == '0);
            @(negedge clk) acc = req_valid & req_ready;
            next_cycle();
        end
        chk("drain", 64'(drained), 64'd1);
        repeat (5) next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
